// File: rtl/touch_scan_ctrl.sv
// Touch panel ADC sequencer: debounces pen-down, alternates X/Y conversion
// requests to the SPI master, averages 2^AVG_LOG2 pairs and publishes them.
module touch_scan_ctrl #(
   parameter int         DEBOUNCE_CYC = 1024,
   parameter int         GAP_CYC      = 4096,
   parameter int         AVG_LOG2     = 2,
   parameter int         TIMEOUT_CYC  = 8191,
   parameter logic [7:0] CMD_X        = 8'hD0,
   parameter logic [7:0] CMD_Y        = 8'h90
) (
   input  logic        sys_clk,
   input  logic        iRST,
   input  logic        penirq_n,
   input  logic        adc_ack,
   input  logic [11:0] adc_data,
   output logic        adc_req,
   output logic [7:0]  adc_cmd,
   output logic [7:0]  x_in,
   output logic [9:0]  y_in,
   output logic        new_coord_r,
   output logic        transmit_en,
   output logic        adc_timeout
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int SMP_W = AVG_LOG2 + 1;
   localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      REQ_X,
      REQ_Y,
      PUBLISH,
      GAP,
      RELEASE
   } state_t;

   state_t             state;
   logic               pen_meta;
   logic               pen;
   logic [DEB_W-1:0]   deb_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [SMP_W-1:0]   smp_cnt;
   logic [ACC_W-1:0]   acc_x;
   logic [ACC_W-1:0]   acc_y;

   always_ff @(posedge sys_clk) begin
      if (iRST) begin
         pen_meta <= 1'b0;
         pen      <= 1'b0;
      end else begin
         pen_meta <= ~penirq_n;
         pen      <= pen_meta;
      end
   end

   // The pen sample taken in IDLE counts as the first debounce cycle.
   always_ff @(posedge sys_clk) begin
      if (iRST) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         gap_cnt     <= '0;
         tmo_cnt     <= '0;
         smp_cnt     <= '0;
         acc_x       <= '0;
         acc_y       <= '0;
         adc_req     <= 1'b0;
         adc_cmd     <= 8'h00;
         x_in        <= 8'h00;
         y_in        <= 10'h000;
         new_coord_r <= 1'b0;
         transmit_en <= 1'b0;
         adc_timeout <= 1'b0;
      end else begin
         new_coord_r <= 1'b0;
         adc_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pen) begin
                  deb_cnt <= DEB_W'(1);
                  state   <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!pen) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  acc_x   <= '0;
                  acc_y   <= '0;
                  smp_cnt <= '0;
                  tmo_cnt <= '0;
                  adc_req <= 1'b1;
                  adc_cmd <= CMD_X;
                  state   <= REQ_X;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            // An ack is only honoured while a request is outstanding; it beats the timeout.
            REQ_X, REQ_Y: begin
               if (!adc_req) begin
                  adc_req <= 1'b1;
                  tmo_cnt <= '0;
               end else if (adc_ack) begin
                  adc_req <= 1'b0;
                  if (state == REQ_X) begin
                     acc_x   <= acc_x + ACC_W'(adc_data);
                     adc_cmd <= CMD_Y;
                     state   <= REQ_Y;
                  end else begin
                     acc_y   <= acc_y + ACC_W'(adc_data);
                     smp_cnt <= smp_cnt + 1'b1;
                     if (smp_cnt == SMP_LAST) begin
                        state <= PUBLISH;
                     end else begin
                        adc_cmd <= CMD_X;
                        state   <= REQ_X;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  adc_req     <= 1'b0;
                  adc_timeout <= 1'b1;
                  transmit_en <= 1'b0;
                  acc_x       <= '0;
                  acc_y       <= '0;
                  smp_cnt     <= '0;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            // Averaging and scaling collapse into a single slice of the top accumulator bits.
            PUBLISH: begin
               x_in        <= acc_x[ACC_W-1 -: 8];
               y_in        <= acc_y[ACC_W-1 -: 10];
               new_coord_r <= 1'b1;
               transmit_en <= 1'b1;
               gap_cnt     <= '0;
               state       <= GAP;
            end
            GAP: begin
               if (!pen) begin
                  state <= RELEASE;
               end else if (gap_cnt == GAP_LAST) begin
                  acc_x   <= '0;
                  acc_y   <= '0;
                  smp_cnt <= '0;
                  tmo_cnt <= '0;
                  adc_req <= 1'b1;
                  adc_cmd <= CMD_X;
                  state   <= REQ_X;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            RELEASE: begin
               transmit_en <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Self-checking bench for touch_scan_ctrl: behavioural ADC responder plus a
// coordinate scoreboard fed by each scenario task.
module tb_touch_scan_ctrl;

   localparam int         DEBOUNCE_CYC = 32;
   localparam int         GAP_CYC      = 64;
   localparam int         AVG_LOG2     = 2;
   localparam int         TIMEOUT_CYC  = 100;
   localparam int         ACK_DELAY    = 20;
   localparam logic [7:0] CMD_X        = 8'hD0;
   localparam logic [7:0] CMD_Y        = 8'h90;

   logic        sys_clk = 1'b0;
   logic        iRST;
   logic        penirq_n;
   logic        adc_ack;
   logic [11:0] adc_data;
   logic        adc_req;
   logic [7:0]  adc_cmd;
   logic [7:0]  x_in;
   logic [9:0]  y_in;
   logic        new_coord_r;
   logic        transmit_en;
   logic        adc_timeout;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic        ack_enable   = 1'b0;
   logic        manual_ack   = 1'b0;
   logic [11:0] x_samp [4];
   logic [11:0] y_samp [4];
   int          x_idx        = 0;
   int          y_idx        = 0;
   int          hs_count     = 0;
   logic [17:0] exp_q [$];

   touch_scan_ctrl #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .GAP_CYC     (GAP_CYC),
      .AVG_LOG2    (AVG_LOG2),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CMD_X       (CMD_X),
      .CMD_Y       (CMD_Y)
   ) dut (
      .sys_clk    (sys_clk),
      .iRST       (iRST),
      .penirq_n   (penirq_n),
      .adc_ack    (adc_ack),
      .adc_data   (adc_data),
      .adc_req    (adc_req),
      .adc_cmd    (adc_cmd),
      .x_in       (x_in),
      .y_in       (y_in),
      .new_coord_r(new_coord_r),
      .transmit_en(transmit_en),
      .adc_timeout(adc_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Mean of four samples, then the 8-bit X / 10-bit Y panel scaling.
   function automatic logic [17:0] expected_coord();
      int sx = 0;
      int sy = 0;
      for (int i = 0; i < 4; i++) begin
         sx += int'(x_samp[i]);
         sy += int'(y_samp[i]);
      end
      sx = sx / 4;
      sy = sy / 4;
      return {8'(sx / 16), 10'(sy / 4)};
   endfunction

   task automatic set_samples(input logic [11:0] x0, x1, x2, x3, y0, y1, y2, y3);
      x_samp[0] = x0; x_samp[1] = x1; x_samp[2] = x2; x_samp[3] = x3;
      y_samp[0] = y0; y_samp[1] = y1; y_samp[2] = y2; y_samp[3] = y3;
      exp_q.push_back(expected_coord());
   endtask

   task automatic wait_coord(input int bound, output logic found, output logic prev_te);
      found   = 1'b0;
      prev_te = transmit_en;
      for (int i = 0; i < bound && !found; i++) begin
         prev_te = transmit_en;
         step();
         if (new_coord_r) found = 1'b1;
      end
   endtask

   task automatic wait_req(input int bound, output int cycles);
      cycles = 0;
      while (!adc_req && cycles < bound) begin
         step();
         cycles++;
      end
   endtask

   // ADC responder: acks ACK_DELAY cycles into each request.
   initial begin : adc_model
      int wait_cnt;
      wait_cnt = 0;
      adc_ack  = 1'b0;
      adc_data = 12'h000;
      forever begin
         step();
         adc_ack = 1'b0;
         if (manual_ack) begin
            adc_ack    = 1'b1;
            adc_data   = 12'hFFF;
            manual_ack = 1'b0;
            wait_cnt   = 0;
         end else if (adc_req && ack_enable) begin
            wait_cnt++;
            if (wait_cnt == ACK_DELAY) begin
               adc_ack = 1'b1;
               if (adc_cmd == CMD_X) begin
                  adc_data = x_samp[x_idx];
                  x_idx    = (x_idx + 1) % 4;
               end else begin
                  adc_data = y_samp[y_idx];
                  y_idx    = (y_idx + 1) % 4;
               end
               hs_count++;
               wait_cnt = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin : scoreboard
      logic [17:0] exp_c;
      forever begin
         step();
         if (new_coord_r) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL unexpected_coord: got x_in=%h y_in=%h, required no publish", x_in, y_in);
            end else begin
               exp_c = exp_q.pop_front();
               if ({x_in, y_in} !== exp_c)
                  begin tests_failed++; $display("[TB] FAIL coord: got x_in=%h y_in=%h, required x_in=%h y_in=%h", x_in, y_in, exp_c[17:10], exp_c[9:0]); end
            end
            tests_run++;
            if (transmit_en !== 1'b1)
               begin tests_failed++; $display("[TB] FAIL te_at_publish: got %b, required 1", transmit_en); end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic test_reset();
      iRST     = 1'b1;
      penirq_n = 1'b1;
      repeat (3) step();
      tests_run++;
      if ({adc_req, adc_cmd} !== 9'h000)
         begin tests_failed++; $display("[TB] FAIL reset_req: got req=%b cmd=%h, required 0/00", adc_req, adc_cmd); end
      tests_run++;
      if ({x_in, y_in, new_coord_r, transmit_en, adc_timeout} !== 21'h0)
         begin tests_failed++; $display("[TB] FAIL reset_out: got x=%h y=%h nc=%b te=%b to=%b, required all 0", x_in, y_in, new_coord_r, transmit_en, adc_timeout); end
      iRST = 1'b0;
      step();
   endtask

   task automatic test_debounce_short();
      logic seen_req;
      seen_req = 1'b0;
      penirq_n = 1'b0;
      for (int i = 0; i < DEBOUNCE_CYC - 1; i++) begin
         step();
         if (adc_req) seen_req = 1'b1;
      end
      penirq_n = 1'b1;
      for (int i = 0; i < 3 * DEBOUNCE_CYC; i++) begin
         step();
         if (adc_req) seen_req = 1'b1;
      end
      tests_run++;
      if (seen_req !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL debounce_short: got adc_req high, required no request"); end
   endtask

   task automatic test_average();
      int   cyc;
      logic found;
      logic prev_te;
      set_samples(12'hA50, 12'hA50, 12'hA50, 12'hA50, 12'h3C8, 12'h3C8, 12'h3C8, 12'h3C8);
      hs_count   = 0;
      ack_enable = 1'b1;
      penirq_n   = 1'b0;
      wait_req(4 * DEBOUNCE_CYC, cyc);
      tests_run++;
      if (cyc != DEBOUNCE_CYC + 2)
         begin tests_failed++; $display("[TB] FAIL req_latency: got %0d cycles, required %0d", cyc, DEBOUNCE_CYC + 2); end
      tests_run++;
      if (adc_cmd !== CMD_X)
         begin tests_failed++; $display("[TB] FAIL first_cmd: got %h, required %h", adc_cmd, CMD_X); end
      wait_coord(8 * (ACK_DELAY + 4) + 20, found, prev_te);
      tests_run++;
      if (found !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL avg_publish: got no new_coord_r, required one"); end
      tests_run++;
      if (hs_count != 8)
         begin tests_failed++; $display("[TB] FAIL handshakes: got %0d, required 8", hs_count); end
      tests_run++;
      if (prev_te !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL te_rise: got te=%b before publish, required 0", prev_te); end
   endtask

   task automatic test_truncate_no_overflow();
      logic found;
      logic prev_te;
      set_samples(12'h100, 12'h101, 12'h102, 12'h103, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      wait_coord(GAP_CYC + 8 * (ACK_DELAY + 4) + 20, found, prev_te);
      tests_run++;
      if (found !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL trunc_publish: got no new_coord_r, required one"); end
      tests_run++;
      if ({x_in, y_in} !== {8'h10, 10'h3FF})
         begin tests_failed++; $display("[TB] FAIL trunc_value: got x=%h y=%h, required x=10 y=3ff", x_in, y_in); end
      tests_run++;
      if (prev_te !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL te_hold: got te=%b between publishes, required 1", prev_te); end
   endtask

   task automatic test_release();
      logic seen_req;
      seen_req = 1'b0;
      penirq_n = 1'b1;
      repeat (3) step();
      tests_run++;
      if (transmit_en !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL release_early: got te=%b after 3 cycles, required 1", transmit_en); end
      step();
      tests_run++;
      if (transmit_en !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL release_late: got te=%b after 4 cycles, required 0", transmit_en); end
      for (int i = 0; i < GAP_CYC + 40; i++) begin
         step();
         if (adc_req) seen_req = 1'b1;
      end
      tests_run++;
      if (seen_req !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL release_req: got adc_req after pen-up, required none"); end
      tests_run++;
      if ({x_in, y_in} !== {8'h10, 10'h3FF})
         begin tests_failed++; $display("[TB] FAIL release_hold: got x=%h y=%h, required x=10 y=3ff", x_in, y_in); end
   endtask

   task automatic test_timeout();
      int   cyc;
      int   high;
      logic found;
      logic prev_te;
      logic seen_bad;
      set_samples(12'hA50, 12'hA50, 12'hA50, 12'hA50, 12'h3C8, 12'h3C8, 12'h3C8, 12'h3C8);
      ack_enable = 1'b1;
      penirq_n   = 1'b0;
      wait_coord(DEBOUNCE_CYC + 8 * (ACK_DELAY + 4) + 40, found, prev_te);
      tests_run++;
      if (found !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL tmo_setup: got no new_coord_r, required one"); end
      ack_enable = 1'b0;
      wait_req(GAP_CYC + 10, cyc);
      penirq_n = 1'b1;
      high = 0;
      while (adc_req && high < TIMEOUT_CYC + 20) begin
         high++;
         step();
      end
      tests_run++;
      if (high != TIMEOUT_CYC)
         begin tests_failed++; $display("[TB] FAIL tmo_len: got req high %0d cycles, required %0d", high, TIMEOUT_CYC); end
      tests_run++;
      if ({adc_timeout, transmit_en} !== 2'b10)
         begin tests_failed++; $display("[TB] FAIL tmo_pulse: got to=%b te=%b, required to=1 te=0", adc_timeout, transmit_en); end
      step();
      tests_run++;
      if (adc_timeout !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL tmo_once: got to=%b next cycle, required 0", adc_timeout); end
      manual_ack = 1'b1;
      seen_bad   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (adc_req || new_coord_r || adc_timeout) seen_bad = 1'b1;
      end
      tests_run++;
      if (seen_bad !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL late_ack: got activity after late ack, required none"); end
   endtask

   task automatic test_reset_inflight();
      int   cyc;
      logic found;
      logic prev_te;
      logic seen_bad;
      set_samples(12'h800, 12'h840, 12'h880, 12'h8C0, 12'h123, 12'h456, 12'h789, 12'hABC);
      ack_enable = 1'b1;
      penirq_n   = 1'b0;
      wait_coord(DEBOUNCE_CYC + 8 * (ACK_DELAY + 4) + 40, found, prev_te);
      tests_run++;
      if (found !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL rst_setup: got no new_coord_r, required one"); end
      ack_enable = 1'b0;
      wait_req(GAP_CYC + 10, cyc);
      tests_run++;
      if (adc_req !== 1'b1)
         begin tests_failed++; $display("[TB] FAIL rst_req: got req=%b, required 1 before reset", adc_req); end
      iRST = 1'b1;
      step();
      tests_run++;
      if ({adc_req, adc_cmd, transmit_en} !== 10'h000)
         begin tests_failed++; $display("[TB] FAIL rst_ctrl: got req=%b cmd=%h te=%b, required 0", adc_req, adc_cmd, transmit_en); end
      tests_run++;
      if ({x_in, y_in, new_coord_r, adc_timeout} !== 20'h0)
         begin tests_failed++; $display("[TB] FAIL rst_data: got x=%h y=%h nc=%b to=%b, required 0", x_in, y_in, new_coord_r, adc_timeout); end
      iRST       = 1'b0;
      penirq_n   = 1'b1;
      manual_ack = 1'b1;
      seen_bad   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (adc_req || new_coord_r || x_in != 8'h00 || y_in != 10'h000) seen_bad = 1'b1;
      end
      tests_run++;
      if (seen_bad !== 1'b0)
         begin tests_failed++; $display("[TB] FAIL rst_ack: got activity after reset ack, required none"); end
   endtask

   initial begin : main
      test_reset();
      test_debounce_short();
      test_average();
      test_truncate_no_overflow();
      test_release();
      test_timeout();
      test_reset_inflight();
      repeat (5) step();
      tests_run++;
      if (exp_q.size() != 0)
         begin tests_failed++; $display("[TB] FAIL missing_coord: got %0d unpublished, required 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
